// File: rtl/dbus_arbiter_pkg.sv
// Shared core types: data-bus request/response bundles and the
// state encoding of the data-bus arbiter.
package common;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } dbus_arb_state_t;

endpackage

// File: rtl/dbus_rr_pick.sv
// Round-robin picker: first index with valid & ~excl, searching
// start+1, start+2, ... modulo N.
//   valid  : per-requester valid bits
//   start  : pointer; the search begins one past it
//   excl   : mask of indices that may not be picked
//   found  : some index qualified
//   index  : the first qualifying index (0 when none)
module dbus_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] start,
    input  logic [N-1:0]         excl,
    output logic                 found,
    output logic [$clog2(N)-1:0] index
);

    int idx;

    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(start) + k) % N;
            if (!found && valid[idx] && !excl[idx]) begin
                found = 1'b1;
                index = idx[$clog2(N)-1:0];
            end
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing the core data bus among N masters;
// the grant is held until the owner's transaction sees data_ok.
//   clk, reset : core clock, synchronous active-low reset
//   ireq/iresp : per-requester request in, response out
//   oreq/oresp : downstream request out, response in
//   busy       : a grant is held
//   owner      : current or most recent grantee
module dbus_arbiter
    import common::*;
#(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  dbus_req_t            ireq  [N],
    output dbus_resp_t           iresp [N],
    output dbus_req_t            oreq,
    input  dbus_resp_t           oresp,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner
);

    localparam int W = $clog2(N);

    dbus_arb_state_t state_q, state_d;
    logic [W-1:0]    owner_q, owner_d;
    logic [W-1:0]    last_q, last_d;

    logic [N-1:0]    valid_vec;
    logic [N-1:0]    excl;
    logic [W-1:0]    start;
    logic            found;
    logic [W-1:0]    pick;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < N; i++) begin
            valid_vec[i] = ireq[i].valid;
        end
    end

    // In BUSY the finishing owner still holds valid high during its
    // data_ok cycle, so it is masked out of the handoff search.
    always_comb begin
        excl  = '0;
        start = last_q;
        if (state_q == ARB_BUSY) begin
            start = owner_q;
            for (int i = 0; i < N; i++) begin
                excl[i] = (owner_q == W'(i));
            end
        end
    end

    dbus_rr_pick #(
        .N(N)
    ) u_pick (
        .valid(valid_vec),
        .start(start),
        .excl (excl),
        .found(found),
        .index(pick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= W'(N - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_BUSY;
                    owner_d = pick;
                    last_d  = pick;
                end
            end
            ARB_BUSY: begin
                if (oresp.data_ok) begin
                    if (found) begin
                        owner_d = pick;
                        last_d  = pick;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ARB_BUSY);
        owner = owner_q;
        oreq  = '0;
        if (busy) begin
            oreq = ireq[owner_q];
        end
        for (int j = 0; j < N; j++) begin
            iresp[j] = '0;
            if (busy && owner_q == W'(j)) begin
                iresp[j] = oresp;
            end
        end
    end

endmodule
